// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
// Instruction-fetch stage of the MIPS pipeline. Holds the program counter,
// presents it to the external incrementer and instruction memory, and latches
// the fetched instruction plus incremented PC into the IF/ID register.
// Supports hazard stall, taken-branch redirect with IF/ID flush, and a
// free-running count of instructions latched into IF/ID.
//
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous, active-high reset
//   pc_out        out  WIDTH  current PC (incrementer input, imem address)
//   npc_in        in   WIDTH  incrementer result, pc_out + 1
//   instr_in      in   WIDTH  imem read data for pc_out (same cycle)
//   stall         in   1      hold request from the hazard unit
//   branch_taken  in   1      redirect request (PCSrc)
//   branch_target in   WIDTH  redirect address
//   ifid_instr    out  WIDTH  IF/ID instruction, 0 is a NOP
//   ifid_npc      out  WIDTH  IF/ID incremented PC
//   ifid_valid    out  1      IF/ID holds a real fetched instruction
//   fetch_count   out  WIDTH  instructions latched into IF/ID since reset

module pc_fetch_stage #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WIDTH-1:0]   pc_out,
    input  logic [WIDTH-1:0]   npc_in,
    input  logic [WIDTH-1:0]   instr_in,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [WIDTH-1:0]   branch_target,
    output logic [WIDTH-1:0]   ifid_instr,
    output logic [WIDTH-1:0]   ifid_npc,
    output logic               ifid_valid,
    output logic [WIDTH-1:0]   fetch_count
);

    // Exactly one of these actions happens on every edge.
    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_STALL,
        ACT_ADVANCE
    } fetchAction_t;

    fetchAction_t fetchAction;

    // Priority decode: reset beats redirect, and redirect beats stall, so a
    // taken branch is never lost behind a hazard hold.
    always_comb begin
        fetchAction = ACT_ADVANCE;
        if (rst) begin
            fetchAction = ACT_RESET;
        end else if (branch_taken) begin
            fetchAction = ACT_REDIRECT;
        end else if (stall) begin
            fetchAction = ACT_STALL;
        end
    end

    // PC, IF/ID register and fetch counter. The stage does no PC arithmetic
    // itself; the incremented value always comes from npc_in, so wrap-around
    // at the top of the address space is whatever the incrementer produces.
    // A stall simply writes nothing, leaving every output bit-identical.
    always_ff @(posedge clk) begin
        case (fetchAction)
            ACT_RESET: begin
                pc_out      <= RESET_PC;
                ifid_instr  <= '0;
                ifid_npc    <= '0;
                ifid_valid  <= 1'b0;
                fetch_count <= '0;
            end
            ACT_REDIRECT: begin
                pc_out      <= branch_target;
                ifid_instr  <= '0;
                ifid_npc    <= '0;
                ifid_valid  <= 1'b0;
            end
            ACT_STALL: begin
                pc_out      <= pc_out;
            end
            default: begin
                pc_out      <= npc_in;
                ifid_instr  <= instr_in;
                ifid_npc    <= npc_in;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage
// Self-checking bench for pc_fetch_stage. A 32-bit instance is driven with a
// behavioural instruction memory (imem[a] = 0x1000 + a) and incrementer; the
// expected IF state for each edge is pushed to a scoreboard queue when the
// inputs are driven and popped for comparison after the edge. A 4-bit
// instance exercises fetch_count and PC wrap-around in a handful of cycles.

module tb_pc_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic [31:0] count;
    } expState_t;

    logic        clk;
    logic        rst;
    logic [31:0] pcOut;
    logic [31:0] npcIn;
    logic [31:0] instrIn;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] ifidInstr;
    logic [31:0] ifidNpc;
    logic        ifidValid;
    logic [31:0] fetchCount;

    logic        nRst;
    logic [3:0]  nPcOut;
    logic [3:0]  nNpcIn;
    logic [3:0]  nInstrIn;
    logic        nStall;
    logic        nBranchTaken;
    logic [3:0]  nBranchTarget;
    logic [3:0]  nIfidInstr;
    logic [3:0]  nIfidNpc;
    logic        nIfidValid;
    logic [3:0]  nFetchCount;

    int checks = 0;
    int errors = 0;

    expState_t   sbQueue[$];
    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mNpc;
    logic        mValid;
    logic [31:0] mCount;

    pc_fetch_stage #(.WIDTH(32), .RESET_PC(32'd0)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_out        (pcOut),
        .npc_in        (npcIn),
        .instr_in      (instrIn),
        .stall         (stall),
        .branch_taken  (branchTaken),
        .branch_target (branchTarget),
        .ifid_instr    (ifidInstr),
        .ifid_npc      (ifidNpc),
        .ifid_valid    (ifidValid),
        .fetch_count   (fetchCount)
    );

    pc_fetch_stage #(.WIDTH(4), .RESET_PC(4'd0)) dutNarrow (
        .clk           (clk),
        .rst           (nRst),
        .pc_out        (nPcOut),
        .npc_in        (nNpcIn),
        .instr_in      (nInstrIn),
        .stall         (nStall),
        .branch_taken  (nBranchTaken),
        .branch_target (nBranchTarget),
        .ifid_instr    (nIfidInstr),
        .ifid_npc      (nIfidNpc),
        .ifid_valid    (nIfidValid),
        .fetch_count   (nFetchCount)
    );

    function automatic logic [31:0] imem(input logic [31:0] addr);
        return 32'h0000_1000 + addr;
    endfunction

    // External incrementer and asynchronous-read instruction memory.
    assign npcIn    = pcOut + 32'd1;
    assign instrIn  = imem(pcOut);
    assign nNpcIn   = nPcOut + 4'd1;
    assign nInstrIn = nPcOut ^ 4'hA;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard upper bound on simulated time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, predict the state after
    // the next rising edge, then compare once it has been taken.
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [31:0] t);
        expState_t e;
        expState_t got;
        @(negedge clk);
        rst          = r;
        stall        = s;
        branchTaken  = b;
        branchTarget = t;
        if (r) begin
            e.pc = 32'd0; e.instr = 32'd0; e.npc = 32'd0; e.valid = 1'b0; e.count = 32'd0;
        end else if (b) begin
            e.pc = t; e.instr = 32'd0; e.npc = 32'd0; e.valid = 1'b0; e.count = mCount;
        end else if (s) begin
            e.pc = mPc; e.instr = mInstr; e.npc = mNpc; e.valid = mValid; e.count = mCount;
        end else begin
            e.pc = mPc + 32'd1; e.instr = imem(mPc); e.npc = mPc + 32'd1;
            e.valid = 1'b1; e.count = mCount + 32'd1;
        end
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        got = sbQueue.pop_front();
        checkOutput("pc_out", pcOut, got.pc);
        checkOutput("ifid_instr", ifidInstr, got.instr);
        checkOutput("ifid_npc", ifidNpc, got.npc);
        checkOutput("ifid_valid", {31'd0, ifidValid}, {31'd0, got.valid});
        checkOutput("fetch_count", fetchCount, got.count);
        mPc    = got.pc;
        mInstr = got.instr;
        mNpc   = got.npc;
        mValid = got.valid;
        mCount = got.count;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'd0;
        nRst = 1'b1; nStall = 1'b0; nBranchTaken = 1'b0; nBranchTarget = 4'd0;
        mPc = 32'd0; mInstr = 32'd0; mNpc = 32'd0; mValid = 1'b0; mCount = 32'd0;

        // Reset for two cycles, then free-run three fetches.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("runPc", pcOut, 32'd3);
        checkOutput("runInstr", ifidInstr, 32'h1002);
        checkOutput("runCount", fetchCount, 32'd3);

        // Three-cycle stall at PC 3, then release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
            checkOutput("stallPc", pcOut, 32'd3);
            checkOutput("stallInstr", ifidInstr, 32'h1002);
            checkOutput("stallCount", fetchCount, 32'd3);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("releaseInstr", ifidInstr, 32'h1003);
        checkOutput("releasePc", pcOut, 32'd4);

        // Redirect while stalled: redirect wins.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd15);
        checkOutput("redirPc", pcOut, 32'd15);
        checkOutput("redirValid", {31'd0, ifidValid}, 32'd0);
        checkOutput("redirCount", fetchCount, 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("targetInstr", ifidInstr, 32'h100F);
        checkOutput("targetNpc", ifidNpc, 32'd16);

        // Back-to-back redirects keep IF/ID invalid.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h30);
        checkOutput("b2bPc", pcOut, 32'h30);

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("wrapPc", pcOut, 32'd0);
        checkOutput("wrapNpc", ifidNpc, 32'd0);

        // Reset while stall and redirect are both requested.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOutput("rstPc", pcOut, 32'd0);
        checkOutput("rstCount", fetchCount, 32'd0);

        // Mixed random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0, $urandom);
        end

        // Narrow instance: 16 advances wrap both fetch_count and PC to 0.
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        nRst = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        checkOutput("narrowCount15", {28'd0, nFetchCount}, 32'd15);
        checkOutput("narrowPc15", {28'd0, nPcOut}, 32'd15);
        @(negedge clk);
        checkOutput("narrowCountWrap", {28'd0, nFetchCount}, 32'd0);
        checkOutput("narrowPcWrap", {28'd0, nPcOut}, 32'd0);
        checkOutput("narrowNpcWrap", {28'd0, nIfidNpc}, 32'd0);
        checkOutput("narrowInstr", {28'd0, nIfidInstr}, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
